// File: rtl/ctrl_pipe_id.sv
// ctrl_pipe_id: registered ID-stage decoder with load-use stall and syscall halt sequencing.
// Optional macro CTRL_STALL_COUNTER_EN enables the saturating load-use stall counter.
module ctrl_pipe_id #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int STALL_CNT_W  = 32,
    parameter int LINK_REG     = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [5:0]             id_op,
    input  logic [5:0]             id_func,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   ex_flush,
    input  logic                   resume,
    output logic                   stall,
    output logic                   ex_valid,
    output logic [3:0]             ex_alu_op,
    output logic                   ex_memtoreg,
    output logic                   ex_memwrite,
    output logic                   ex_alu_src,
    output logic                   ex_regwrite,
    output logic                   ex_signedext,
    output logic                   ex_shiftv,
    output logic                   ex_lui,
    output logic [2:0]             ex_br,
    output logic                   ex_jal,
    output logic [1:0]             ex_mode,
    output logic [REG_W-1:0]       ex_wreg,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);
    typedef struct packed {
        logic             valid;
        logic [3:0]       alu_op;
        logic             memtoreg;
        logic             memwrite;
        logic             alu_src;
        logic             regwrite;
        logic             signedext;
        logic             shiftv;
        logic             lui;
        logic [2:0]       br;
        logic             jal;
        logic [1:0]       mode;
        logic [REG_W-1:0] wreg;
    } ctrl_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    ctrl_t dec, ex;
    state_t state;
    logic [3:0] cnt;
    logic r_ok, is_sys, rs_used, rt_used, hz, issue;
    assign is_sys  = id_op == 6'd0 && id_func == 6'd12;
    assign r_ok    = id_func inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8,
                                     [6'd32:6'd39], 6'd42, 6'd43};
    assign rs_used = !(id_op inside {6'd2, 6'd3, 6'd15} ||
                       (id_op == 6'd0 && id_func inside {6'd0, 6'd2, 6'd3}));
    assign rt_used = (id_op == 6'd0 && id_func != 6'd12 && id_func != 6'd8) ||
                     id_op inside {6'd4, 6'd5, 6'd40, 6'd41, 6'd43};
    assign hz = id_valid && ex.valid && ex.memtoreg && ex.wreg != '0 &&
                ((rs_used && id_rs == ex.wreg) || (rt_used && id_rt == ex.wreg));
    assign stall = state != RUN || (hz && !ex_flush);
    assign issue = state == RUN && id_valid && !ex_flush && !hz && !is_sys;
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.wreg  = id_op == 6'd3 ? REG_W'(LINK_REG) : id_rt;
        case (id_op)
            6'd0: begin
                case (id_func)
                    6'd2, 6'd6:   dec.alu_op = 4'd2;
                    6'd3, 6'd7:   dec.alu_op = 4'd1;
                    6'd32, 6'd33: dec.alu_op = 4'd5;
                    6'd34, 6'd35: dec.alu_op = 4'd6;
                    6'd36:        dec.alu_op = 4'd7;
                    6'd37:        dec.alu_op = 4'd8;
                    6'd38:        dec.alu_op = 4'd9;
                    6'd39:        dec.alu_op = 4'd10;
                    6'd42:        dec.alu_op = 4'd11;
                    6'd43:        dec.alu_op = 4'd12;
                    default:      dec.alu_op = 4'd0;
                endcase
                dec.shiftv   = id_func inside {6'd4, 6'd6, 6'd7};
                dec.br       = id_func == 6'd8 ? 3'd7 : 3'd0;
                dec.regwrite = r_ok && id_func != 6'd8;
                dec.wreg     = r_ok ? id_rd : '0;
            end
            6'd1: {dec.br, dec.alu_op, dec.signedext} = {3'd5, 4'd6, 1'b1};
            6'd2: dec.br = 3'd6;
            6'd3: {dec.br, dec.jal, dec.regwrite} = {3'd6, 1'b1, 1'b1};
            6'd4, 6'd5, 6'd6, 6'd7: begin
                dec.br        = id_op[2:0] - 3'd3;
                dec.alu_op    = 4'd6;
                dec.signedext = 1'b1;
            end
            6'd8, 6'd9, 6'd10, 6'd11: begin
                dec.alu_op    = id_op == 6'd10 ? 4'd11 : id_op == 6'd11 ? 4'd12 : 4'd5;
                dec.alu_src   = 1'b1;
                dec.regwrite  = 1'b1;
                dec.signedext = 1'b1;
            end
            6'd12, 6'd13, 6'd14: begin
                dec.alu_op   = id_op[3:0] - 4'd5;
                dec.alu_src  = 1'b1;
                dec.regwrite = 1'b1;
            end
            6'd15: {dec.lui, dec.alu_op, dec.alu_src, dec.regwrite} = {1'b1, 4'd5, 1'b1, 1'b1};
            6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43: begin
                dec.memtoreg  = !id_op[3];
                dec.memwrite  = id_op[3];
                dec.regwrite  = !id_op[3];
                dec.alu_src   = 1'b1;
                dec.signedext = 1'b1;
                dec.alu_op    = 4'd5;
                dec.mode      = id_op[1:0] == 2'b11 ? 2'd2 : {1'b0, id_op[0]};
            end
            default: dec.wreg = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex     <= '0;
            state  <= RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            ex <= issue ? dec : '0;
            case (state)
                RUN: if (id_valid && is_sys && !ex_flush && !hz) begin
                    state <= DRAIN;
                    cnt   <= 4'(DRAIN_CYCLES);
                end
                DRAIN: if (cnt == '0) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end else cnt <= cnt - 4'd1;
                default: if (resume) begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end
`ifdef CTRL_STALL_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_count <= '0;
        else if (state == RUN && hz && !ex_flush && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
`else
    assign stall_count = '0;
`endif
    assign ex_valid     = ex.valid;
    assign ex_alu_op    = ex.alu_op;
    assign ex_memtoreg  = ex.memtoreg;
    assign ex_memwrite  = ex.memwrite;
    assign ex_alu_src   = ex.alu_src;
    assign ex_regwrite  = ex.regwrite;
    assign ex_signedext = ex.signedext;
    assign ex_shiftv    = ex.shiftv;
    assign ex_lui       = ex.lui;
    assign ex_br        = ex.br;
    assign ex_jal       = ex.jal;
    assign ex_mode      = ex.mode;
    assign ex_wreg      = ex.wreg;
endmodule

// File: tb/tb_ctrl_pipe_id.sv
// tb_ctrl_pipe_id: directed scenario bench for the ID-stage control unit.
module tb_ctrl_pipe_id;
    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid = 1'b0, ex_flush = 1'b0, resume = 1'b0;
    logic [5:0] id_op = '0, id_func = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic stall, ex_valid, ex_memtoreg, ex_memwrite, ex_alu_src, ex_regwrite;
    logic ex_signedext, ex_shiftv, ex_lui, ex_jal, halted;
    logic [3:0] ex_alu_op;
    logic [2:0] ex_br;
    logic [1:0] ex_mode;
    logic [4:0] ex_wreg;
    logic [31:0] stall_count;
    int errors = 0, checks = 0;
`ifdef CTRL_STALL_COUNTER_EN
    localparam logic [31:0] LU_CNT = 32'd2;
`else
    localparam logic [31:0] LU_CNT = 32'd0;
`endif

    ctrl_pipe_id dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush), .resume(resume),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_alu_src(ex_alu_src), .ex_regwrite(ex_regwrite),
        .ex_signedext(ex_signedext), .ex_shiftv(ex_shiftv), .ex_lui(ex_lui), .ex_br(ex_br),
        .ex_jal(ex_jal), .ex_mode(ex_mode), .ex_wreg(ex_wreg), .halted(halted),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v; id_op = op; id_func = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        checks++; if ({ex_alu_op, ex_br, ex_wreg, ex_mode} !== 14'd0) begin errors++; $display("FAIL reset_bundle got %h want 0", {ex_alu_op, ex_br, ex_wreg, ex_mode}); end
        checks++; if (halted !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_halt got halted=%b stall=%b want 0 0", halted, stall); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_count); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set_in(1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got %b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_alu_op !== 4'd5) begin errors++; $display("FAIL add_op got v=%b op=%0d want 1 5", ex_valid, ex_alu_op); end
        checks++; if (ex_regwrite !== 1'b1 || ex_wreg !== 5'd3) begin errors++; $display("FAIL add_wb got rw=%b wreg=%0d want 1 3", ex_regwrite, ex_wreg); end
        checks++; if ({ex_memtoreg, ex_memwrite, ex_alu_src, ex_br} !== 6'd0) begin errors++; $display("FAIL add_misc got %b want 0", {ex_memtoreg, ex_memwrite, ex_alu_src, ex_br}); end
    endtask

    task automatic test_load_use();
        set_in(1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        checks++; if ({ex_memtoreg, ex_alu_src, ex_regwrite, ex_mode, ex_wreg} !== {3'b111, 2'd2, 5'd5}) begin errors++; $display("FAIL lw_decode got %b want %b", {ex_memtoreg, ex_alu_src, ex_regwrite, ex_mode, ex_wreg}, {3'b111, 2'd2, 5'd5}); end
        set_in(1, 6'd0, 6'd32, 5'd5, 5'd2, 5'd6);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%b stall=%b want 0 0", ex_valid, stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd6) begin errors++; $display("FAIL lu_issue got v=%b wreg=%0d want 1 6", ex_valid, ex_wreg); end
        set_in(1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        set_in(1, 6'd43, 6'd0, 5'd1, 5'd5, 5'd0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_stall got %b want 1", stall); end
        tick();
        tick();
        checks++; if (ex_memwrite !== 1'b1 || ex_mode !== 2'd2) begin errors++; $display("FAIL sw_decode got mw=%b mode=%0d want 1 2", ex_memwrite, ex_mode); end
        checks++; if (stall_count !== LU_CNT) begin errors++; $display("FAIL lu_count got %0d want %0d", stall_count, LU_CNT); end
    endtask

    task automatic test_no_hazard();
        set_in(1, 6'd35, 6'd0, 5'd1, 5'd0, 5'd0);
        tick();
        set_in(1, 6'd0, 6'd32, 5'd0, 5'd0, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_nostall got %b want 0", stall); end
        tick();
        set_in(1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        set_in(1, 6'd2, 6'd0, 5'd5, 5'd0, 5'd0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL j_nostall got %b want 0", stall); end
        tick();
        checks++; if (ex_br !== 3'd6 || ex_regwrite !== 1'b0) begin errors++; $display("FAIL j_decode got br=%0d rw=%b want 6 0", ex_br, ex_regwrite); end
        set_in(1, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        checks++; if ({ex_jal, ex_regwrite, ex_br, ex_wreg} !== {2'b11, 3'd6, 5'd31}) begin errors++; $display("FAIL jal_decode got %b want %b", {ex_jal, ex_regwrite, ex_br, ex_wreg}, {2'b11, 3'd6, 5'd31}); end
    endtask

    task automatic test_decode();
        set_in(1, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        checks++; if ({ex_br, ex_alu_op, ex_signedext, ex_regwrite} !== {3'd1, 4'd6, 2'b10}) begin errors++; $display("FAIL beq_decode got %b want %b", {ex_br, ex_alu_op, ex_signedext, ex_regwrite}, {3'd1, 4'd6, 2'b10}); end
        set_in(1, 6'd0, 6'd3, 5'd0, 5'd2, 5'd4);
        tick();
        checks++; if ({ex_alu_op, ex_shiftv, ex_wreg} !== {4'd1, 1'b0, 5'd4}) begin errors++; $display("FAIL sra_decode got %b want %b", {ex_alu_op, ex_shiftv, ex_wreg}, {4'd1, 1'b0, 5'd4}); end
        set_in(1, 6'd0, 6'd4, 5'd1, 5'd2, 5'd4);
        tick();
        checks++; if (ex_alu_op !== 4'd0 || ex_shiftv !== 1'b1) begin errors++; $display("FAIL sllv_decode got op=%0d sv=%b want 0 1", ex_alu_op, ex_shiftv); end
        set_in(1, 6'd15, 6'd0, 5'd0, 5'd7, 5'd0);
        tick();
        checks++; if ({ex_lui, ex_alu_src, ex_regwrite, ex_wreg} !== {3'b111, 5'd7}) begin errors++; $display("FAIL lui_decode got %b want %b", {ex_lui, ex_alu_src, ex_regwrite, ex_wreg}, {3'b111, 5'd7}); end
        set_in(1, 6'd33, 6'd0, 5'd1, 5'd8, 5'd0);
        tick();
        checks++; if (ex_mode !== 2'd1 || ex_memtoreg !== 1'b1) begin errors++; $display("FAIL lh_decode got mode=%0d m2r=%b want 1 1", ex_mode, ex_memtoreg); end
        set_in(1, 6'd63, 6'd0, 5'd1, 5'd9, 5'd3);
        tick();
        checks++; if (ex_valid !== 1'b1 || {ex_alu_op, ex_regwrite, ex_wreg, ex_br} !== 13'd0) begin errors++; $display("FAIL undef_nop got v=%b bits=%h want 1 0", ex_valid, {ex_alu_op, ex_regwrite, ex_wreg, ex_br}); end
        set_in(0, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3);
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_wreg !== 5'd0) begin errors++; $display("FAIL invalid_bubble got v=%b rw=%b wreg=%0d want 0 0 0", ex_valid, ex_regwrite, ex_wreg); end
    endtask

    task automatic test_flush();
        set_in(1, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        set_in(1, 6'd0, 6'd12, 5'd0, 5'd0, 5'd0);
        ex_flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        tick();
        ex_flush = 1'b0;
        set_in(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        checks++; if (ex_valid !== 1'b0 || ex_br !== 3'd0) begin errors++; $display("FAIL flush_bubble got v=%b br=%0d want 0 0", ex_valid, ex_br); end
        tick();
        checks++; if (stall !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL flush_run got stall=%b halted=%b want 0 0", stall, halted); end
    endtask

    task automatic test_syscall();
        set_in(1, 6'd0, 6'd12, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sys_accept got stall=%b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL sys_bubble got v=%b stall=%b want 0 1", ex_valid, stall); end
        set_in(1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3);
        ex_flush = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            ex_flush = 1'b0;
            checks++; if (halted !== 1'b0 || stall !== 1'b1 || ex_valid !== 1'b0) begin errors++; $display("FAIL sys_drain%0d got h=%b s=%b v=%b want 0 1 0", i, halted, stall, ex_valid); end
        end
        tick();
        checks++; if (halted !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sys_halted got h=%b s=%b want 1 1", halted, stall); end
        tick();
        checks++; if (halted !== 1'b1 || ex_valid !== 1'b0) begin errors++; $display("FAIL sys_hold got h=%b v=%b want 1 0", halted, ex_valid); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++; if (halted !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL sys_resume got h=%b s=%b want 0 0", halted, stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd3) begin errors++; $display("FAIL sys_after got v=%b wreg=%0d want 1 3", ex_valid, ex_wreg); end
    endtask

    task automatic test_reset_drain();
        set_in(1, 6'd0, 6'd12, 5'd0, 5'd0, 5'd0);
        tick();
        set_in(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rd_pre got stall=%b want 1", stall); end
        rst_n = 1'b0;
        #1;
        checks++; if ({stall, halted, ex_valid, ex_regwrite} !== 4'd0) begin errors++; $display("FAIL rd_async got %b want 0000", {stall, halted, ex_valid, ex_regwrite}); end
        #2;
        rst_n = 1'b1;
        set_in(1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_run got stall=%b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_alu_op !== 4'd5 || ex_wreg !== 5'd3) begin errors++; $display("FAIL rd_issue got v=%b op=%0d wreg=%0d want 1 5 3", ex_valid, ex_alu_op, ex_wreg); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_no_hazard();
        test_decode();
        test_flush();
        test_syscall();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_id.md
Name: ctrl_pipe_id

Overview:
- Registered ID-stage control unit for the pipelined MIPS core.
- Decodes op/func each cycle into the control bundle and latches it into the ID/EX control register.
- Detects load-use hazards and applies flush and stall rules.
- Sequences a syscall halt: the pipeline drains, then the core halts.
- Sits between the IF/ID instruction register and the EX stage; replaces the single-cycle combinational decoder.

Parameters:
- REG_W, 5, register address width.
- DRAIN_CYCLES, 3, bubble cycles inserted after a syscall before halted asserts (1..15).
- STALL_CNT_W, 32, width of the load-use stall counter.
- LINK_REG, 31, destination register written by JAL.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_op  in  6  opcode field
- id_func  in  6  function field
- id_rs  in  REG_W  rs field
- id_rt  in  REG_W  rt field
- id_rd  in  REG_W  rd field
- ex_flush  in  1  branch/jump taken in EX; kill the instruction in ID
- resume  in  1  one-cycle pulse, leave HALTED
- stall  out  1  combinational; hold PC and IF/ID
- ex_valid  out  1  ID/EX slot holds a real instruction
- ex_alu_op  out  4  ADD=5 SLL=0 SRA=1 SRL=2 SUB=6 AND=7 OR=8 XOR=9 NOR=10 SLT=11 SLTU=12
- ex_memtoreg, ex_memwrite, ex_alu_src, ex_regwrite, ex_signedext, ex_shiftv, ex_lui  out  1 each  registered control bits
- ex_br  out  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 regimm(op=1), 6 j/jal, 7 jr
- ex_jal  out  1  link write
- ex_mode  out  2  00 byte, 01 half, 10 word
- ex_wreg  out  REG_W  destination: rd for R-type, LINK_REG for JAL, rt otherwise
- halted  out  1  core halted
- stall_count  out  STALL_CNT_W  load-use stall cycles

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0, halted=0, stall_count=0, FSM=RUN.
- Decode is combinational from id_op/id_func.
  - R-type means op=0 and not SYSCALL (func=12).
  - Undecoded opcodes produce an all-zero bundle with ex_valid=1 (NOP).
- Latency: exactly 1 cycle from ID to the ex_* outputs.
- Source use:
  - rs is used by everything except J, JAL, LUI and SLL/SRL/SRA.
  - rt is used by R-type (except JR), BEQ, BNE, SB, SH, SW.
- Hazard condition: hz = id_valid & ex_valid & ex_memtoreg & ex_wreg!=0 & ((rs_used & id_rs==ex_wreg) | (rt_used & id_rt==ex_wreg)).
- Per-cycle priority (in RUN state):
  - ex_flush=1: ID/EX is loaded with a bubble (ex_valid=0, all bits 0); stall=0; a syscall in ID is ignored.
  - Else hz=1: stall=1 and a bubble is loaded; the instruction stays in ID and retries next cycle.
  - Else: the bundle is loaded with ex_valid=id_valid; a bubble with id_valid=0 has all bits 0.
- Halt FSM:
  - RUN -> DRAIN when id_valid & SYSCALL & !ex_flush & !hz. The syscall itself enters EX as a bubble. The drain counter loads DRAIN_CYCLES.
  - DRAIN: stall=1 and a bubble is loaded every cycle. The counter decrements; at counter 0 the FSM moves to HALTED on the next edge.
  - HALTED: halted=1, stall=1, bubbles continue. On resume=1 the FSM returns to RUN; halted deasserts on that edge.
  - ex_flush and resume are ignored in DRAIN. resume is ignored in RUN and DRAIN.
  - Reset mid-DRAIN or in HALTED returns to RUN with the counter cleared.
- halted is registered and asserts DRAIN_CYCLES+1 edges after the syscall edge.

Optional Feature:
- Macro: CTRL_STALL_COUNTER_EN.
- Defined: stall_count increments on every RUN-state cycle with hz=1 and ex_flush=0. It saturates at all-ones and does not count drain or halt stalls.
- Undefined: stall_count is tied to 0 and no counter flops are generated.

Test Plan:
- ADD $3,$1,$2 (op0 f32) with id_valid=1 -> next edge: ex_valid=1, ex_alu_op=5, ex_regwrite=1, ex_wreg=3, stall=0.
- LW $5,0($1) followed by ADD $6,$5,$2 -> 1 cycle stall=1 with a bubble in EX, then ADD issues; stall_count=1 when the macro is defined.
- LW $0 followed by a use of $0 -> no stall; LW $5 followed by J -> no stall (rs unused).
- BEQ in EX with ex_flush=1 while a syscall is in ID -> bubble, FSM stays RUN, halted=0.
- SYSCALL with DRAIN_CYCLES=3 -> stall=1 from the next cycle, halted=1 after 4 edges; resume pulse -> halted=0, stall=0 the next cycle.
- rst_n pulled low mid-DRAIN -> all outputs 0 immediately; after release FSM=RUN and an ADD issues normally.
